// File: rtl/srgl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | srgl_pkg: shared types, LDR decode and width helpers for the        |
// | sign-language glove stream matcher.                 Revision: 1.0   |
// +--------------------------------------------------------------------+
package srgl_pkg;

    localparam logic [7:0] c_ascii_unknown = 8'h3F;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_ERR     = 2'd2,
        ST_DECIDE  = 2'd3
    } state_t;

    // Index width that never collapses to zero bits for tiny counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int sum_w(input int sample_w, input int n);
        return sample_w + $clog2(n);
    endfunction

    function automatic int err_w(input int sample_w, input int n);
        return sample_w + 2 * $clog2(n) + 2;
    endfunction

    function automatic logic [7:0] ldr_decode(input logic [4:0] pattern);
        logic [7:0] letter;
        case (pattern)
            5'b00001: letter = 8'h41; // A
            5'b11110: letter = 8'h42; // B
            5'b11111: letter = 8'h43; // C
            5'b00010: letter = 8'h44; // D
            5'b11101: letter = 8'h46; // F
            5'b00110: letter = 8'h55; // U
            5'b00101: letter = 8'h48; // H
            5'b10000: letter = 8'h49; // I
            5'b00011: letter = 8'h4C; // L
            5'b01110: letter = 8'h57; // W
            5'b10001: letter = 8'h59; // Y
            5'b00000: letter = 8'h53; // S
            default:  letter = c_ascii_unknown;
        endcase
        return letter;
    endfunction

endpackage : srgl_pkg
`default_nettype wire

// File: rtl/srgl_template_store.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | srgl_template_store: runtime-loadable gesture template bank with    |
// | async point read and base-letter lookup.            Revision: 1.0   |
// +--------------------------------------------------------------------+
module srgl_template_store
    import srgl_pkg::*;
#(
    parameter  int N_SAMPLES   = 30,
    parameter  int SAMPLE_W    = 32,
    parameter  int N_TEMPLATES = 4,
    parameter  int TOL_W       = 32,
    localparam int TMPL_W      = clog2_min1(N_TEMPLATES),
    localparam int ADDR_W      = clog2_min1(N_SAMPLES + 3),
    localparam int IDX_W       = clog2_min1(N_SAMPLES)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_cfg_we,
    input  logic [TMPL_W-1:0]          i_cfg_tmpl,
    input  logic [ADDR_W-1:0]          i_cfg_addr,
    input  logic [SAMPLE_W-1:0]        i_cfg_data,
    input  logic [TMPL_W-1:0]          i_rd_sel,
    input  logic [IDX_W-1:0]           i_rd_idx,
    output logic signed [SAMPLE_W-1:0] o_rd_point,
    output logic [7:0]                 o_rd_target,
    output logic [TOL_W-1:0]           o_rd_tol,
    input  logic [7:0]                 i_lookup_letter,
    output logic [TMPL_W-1:0]          o_lookup_sel,
    output logic                       o_lookup_hit
);

    logic signed [SAMPLE_W-1:0] r_model  [N_TEMPLATES][N_SAMPLES];
    logic [7:0]                 r_base   [N_TEMPLATES];
    logic [7:0]                 r_target [N_TEMPLATES];
    logic [TOL_W-1:0]           r_tol    [N_TEMPLATES];

    logic w_we;
    logic w_pt_we;

    assign w_we    = i_cfg_we && !reset && (int'(i_cfg_tmpl) < N_TEMPLATES);
    assign w_pt_we = w_we && (int'(i_cfg_addr) < N_SAMPLES);

    always_ff @(posedge clk) begin
        if (w_pt_we) begin
            r_model[i_cfg_tmpl][IDX_W'(i_cfg_addr)] <= i_cfg_data;
        end
    end

    // A zero base letter marks the slot as disabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_TEMPLATES; i++) begin
                r_base[i] <= 8'h00;
            end
        end else if (w_we && i_cfg_addr == ADDR_W'(N_SAMPLES)) begin
            r_base[i_cfg_tmpl] <= i_cfg_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (w_we && i_cfg_addr == ADDR_W'(N_SAMPLES + 1)) begin
            r_target[i_cfg_tmpl] <= i_cfg_data[7:0];
        end
        if (w_we && i_cfg_addr == ADDR_W'(N_SAMPLES + 2)) begin
            r_tol[i_cfg_tmpl] <= TOL_W'(i_cfg_data);
        end
    end

    assign o_rd_point  = r_model[i_rd_sel][i_rd_idx];
    assign o_rd_target = r_target[i_rd_sel];
    assign o_rd_tol    = r_tol[i_rd_sel];

    // Scan downwards so the lowest matching slot wins.
    always_comb begin
        o_lookup_sel = '0;
        o_lookup_hit = 1'b0;
        for (int i = N_TEMPLATES - 1; i >= 0; i--) begin
            if (r_base[i] != 8'h00 && r_base[i] == i_lookup_letter) begin
                o_lookup_sel = TMPL_W'(i);
                o_lookup_hit = 1'b1;
            end
        end
    end

endmodule : srgl_template_store
`default_nettype wire

// File: rtl/srgl_stream_matcher.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | srgl_stream_matcher: LDR letter decode plus streamed accelerometer  |
// | window match against a template bank.               Revision: 1.0   |
// +--------------------------------------------------------------------+
module srgl_stream_matcher
    import srgl_pkg::*;
#(
    parameter  int N_SAMPLES   = 30,
    parameter  int SAMPLE_W    = 32,
    parameter  int N_TEMPLATES = 4,
    parameter  int LDR_W       = 5,
    parameter  int TOL_W       = 32,
    localparam int TMPL_W      = clog2_min1(N_TEMPLATES),
    localparam int ADDR_W      = clog2_min1(N_SAMPLES + 3),
    localparam int ERR_W       = err_w(SAMPLE_W, N_SAMPLES)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [LDR_W-1:0]           ldr,
    input  logic                       mov,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic signed [SAMPLE_W-1:0] s_data,
    input  logic                       cfg_we,
    input  logic [TMPL_W-1:0]          cfg_tmpl,
    input  logic [ADDR_W-1:0]          cfg_addr,
    input  logic [SAMPLE_W-1:0]        cfg_data,
    output logic [7:0]                 letra_final,
    output logic                       match_valid,
    output logic                       match,
    output logic [ERR_W-1:0]           err_out
);

    localparam int IDX_W = clog2_min1(N_SAMPLES);
    localparam int CNT_W = clog2_min1(N_SAMPLES + 1);
    localparam int SUM_W = sum_w(SAMPLE_W, N_SAMPLES);
    localparam int D_W   = SUM_W + 2;

    localparam logic [CNT_W-1:0]      c_last = CNT_W'(N_SAMPLES - 1);
    localparam logic [CNT_W-1:0]      c_n    = CNT_W'(N_SAMPLES);
    localparam logic signed [D_W-1:0] c_n_d  = D_W'(N_SAMPLES);
    localparam logic [ERR_W-1:0]      c_nn   = ERR_W'(N_SAMPLES * N_SAMPLES);

    state_t r_state;
    state_t w_state_nxt;

    logic [7:0]              r_base_letter;
    logic [TMPL_W-1:0]       r_sel;
    logic                    r_hit;
    logic [CNT_W-1:0]        r_cnt;
    logic signed [SUM_W-1:0] r_sb;
    logic signed [SUM_W-1:0] r_sm;
    logic [ERR_W-1:0]        r_err;
    logic [ERR_W-1:0]        r_absd;
    logic signed [SAMPLE_W-1:0] r_buf [N_SAMPLES];

    logic [7:0]                 w_letter;
    logic                       w_accept;
    logic                       w_cfg_we;
    logic [IDX_W-1:0]           w_idx;
    logic signed [SAMPLE_W-1:0] w_point;
    logic [7:0]                 w_target;
    logic [TOL_W-1:0]           w_tol;
    logic [TMPL_W-1:0]          w_lk_sel;
    logic                       w_lk_hit;
    logic signed [D_W-1:0]      w_nbuf;
    logic signed [D_W-1:0]      w_nmod;
    logic signed [D_W-1:0]      w_d;
    logic [ERR_W-1:0]           w_absd;
    logic [ERR_W-1:0]           w_thr;
    logic                       w_match;

    assign w_letter = ldr_decode(5'(ldr));
    assign w_accept = (r_state == ST_CAPTURE) && mov && s_valid;
    assign w_cfg_we = cfg_we && (r_state == ST_IDLE);
    assign w_idx    = (r_cnt < c_n) ? IDX_W'(r_cnt) : '0;

    srgl_template_store #(
        .N_SAMPLES   (N_SAMPLES),
        .SAMPLE_W    (SAMPLE_W),
        .N_TEMPLATES (N_TEMPLATES),
        .TOL_W       (TOL_W)
    ) u_store (
        .clk             (clk),
        .reset           (reset),
        .i_cfg_we        (w_cfg_we),
        .i_cfg_tmpl      (cfg_tmpl),
        .i_cfg_addr      (cfg_addr),
        .i_cfg_data      (cfg_data),
        .i_rd_sel        (r_sel),
        .i_rd_idx        (w_idx),
        .o_rd_point      (w_point),
        .o_rd_target     (w_target),
        .o_rd_tol        (w_tol),
        .i_lookup_letter (w_letter),
        .o_lookup_sel    (w_lk_sel),
        .o_lookup_hit    (w_lk_hit)
    );

    // Mean-normalised difference scaled by N so no division is needed.
    assign w_nbuf  = D_W'(r_buf[w_idx]) * c_n_d;
    assign w_nmod  = D_W'(w_point) * c_n_d;
    assign w_d     = (w_nbuf - D_W'(r_sb)) - (w_nmod - D_W'(r_sm));
    assign w_absd  = ERR_W'($unsigned(w_d[D_W-1] ? -w_d : w_d));
    assign w_thr   = ERR_W'(w_tol) * c_nn;
    assign w_match = r_hit && (r_err < w_thr);

    always_comb begin
        w_state_nxt = r_state;
        s_ready     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mov) w_state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                s_ready = 1'b1;
                if (!mov) begin
                    w_state_nxt = ST_IDLE;
                end else if (s_valid && r_cnt == c_last) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_ERR: begin
                if (r_cnt == c_n) w_state_nxt = ST_DECIDE;
            end
            ST_DECIDE: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (w_accept) r_buf[IDX_W'(r_cnt)] <= s_data;
    end

    // |d| is registered one stage ahead of the accumulator, so ERR spends
    // N+1 cycles: N point evaluations plus one to fold in the last term.
    always_ff @(posedge clk) begin
        if (reset) begin
            letra_final   <= c_ascii_unknown;
            match_valid   <= 1'b0;
            match         <= 1'b0;
            err_out       <= '0;
            r_base_letter <= c_ascii_unknown;
            r_sel         <= '0;
            r_hit         <= 1'b0;
            r_cnt         <= '0;
            r_sb          <= '0;
            r_sm          <= '0;
            r_err         <= '0;
            r_absd        <= '0;
        end else begin
            match_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!mov) begin
                        letra_final <= w_letter;
                    end else begin
                        r_base_letter <= w_letter;
                        r_sel         <= w_lk_sel;
                        r_hit         <= w_lk_hit;
                        r_cnt         <= '0;
                        r_sb          <= '0;
                        r_sm          <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (w_accept) begin
                        r_sb <= r_sb + SUM_W'(s_data);
                        r_sm <= r_sm + SUM_W'(w_point);
                        if (r_cnt == c_last) begin
                            r_cnt  <= '0;
                            r_err  <= '0;
                            r_absd <= '0;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_ERR: begin
                    r_absd <= w_absd;
                    r_err  <= r_err + r_absd;
                    r_cnt  <= r_cnt + CNT_W'(1);
                end
                ST_DECIDE: begin
                    match_valid <= 1'b1;
                    match       <= w_match;
                    letra_final <= w_match ? w_target : r_base_letter;
                    err_out     <= r_hit ? r_err : '0;
                end
                default: ;
            endcase
        end
    end

endmodule : srgl_stream_matcher
`default_nettype wire
